unidade_controle_exp6: RTL and testbench
========================================

Name: unidade_controle_exp6

Overview:
Moore FSM that sequences the exp6 memory-game datapath (address counter, play register, sync ROM, comparator, play timer, play edge detector). It starts a round on `iniciar` and waits for each play, bounded by the timer. It registers and compares each play, then steps the address until all 16 positions match, one play mismatches, or the timer expires. It drives every datapath control strobe and exposes end-of-round status plus a state debug code.

Parameters:
TIMEOUT_EN, 1, 1 = `fimT` in `espera_jogada` ends the round as timeout; 0 = `fimT` ignored and the FSM waits indefinitely.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces state `inicial`
iniciar  in  1  start/restart request, level sampled each clock
jogada_feita  in  1  one-cycle pulse from the play edge detector
igual  in  1  ROM data equals registered play
fimC  in  1  address counter at last position (15)
fimT  in  1  play timer expired
zeraC  out  1  clear address counter
contaC  out  1  increment address counter
zeraT  out  1  clear play timer
contaT  out  1  enable play timer
zeraR  out  1  clear play register
registraR  out  1  load play register from chaves
pronto  out  1  round finished (any outcome)
acertou  out  1  round finished, all 16 correct
errou  out  1  round finished, mismatch
timeout  out  1  round finished, timer expired
db_estado  out  4  current state code

Behaviour:
- State register updates on the rising clock edge; `reset`=1 forces `inicial` asynchronously, at any time, including mid-round.
- All outputs are decoded from the state only (Moore): no combinational path from any input to any output.
- While in reset, every output is 0 and `db_estado` = 0x0.
- Outputs not listed in a state are 0.
- States, with codes, asserted outputs and transitions:
  - `inicial` (0x0): no outputs. `iniciar`=1 -> `preparacao`, else stay.
  - `preparacao` (0x1): `zeraC`, `zeraR`, `zeraT`. Goes unconditionally -> `espera_jogada`.
  - `espera_jogada` (0x2): `contaT`.
    - `jogada_feita`=1 -> `registra`.
    - Else `fimT`=1 and TIMEOUT_EN=1 -> `fim_timeout`.
    - Else stay.
    - `jogada_feita` has priority over `fimT` in the same cycle.
  - `registra` (0x4): `registraR`, `zeraT` (timer restarts for each play). Goes unconditionally -> `comparacao`.
  - `comparacao` (0x5): no outputs; the register holds the new play and the ROM output is stable.
    - `igual`=0 -> `fim_erro`.
    - Else `fimC`=1 -> `fim_acerto`.
    - Else -> `proximo`.
    - Mismatch has priority over `fimC`.
  - `proximo` (0x6): `contaC` (one increment). Goes unconditionally -> `espera_jogada`.
  - `fim_acerto` (0xA): `pronto`, `acertou`.
  - `fim_erro` (0xE): `pronto`, `errou`.
  - `fim_timeout` (0xD): `pronto`, `timeout`.
  - All three final states: `iniciar`=1 -> `preparacao`, else hold.
  - Any unused code -> `inicial` on the next clock.
- Exactly one of `acertou`/`errou`/`timeout` is high whenever `pronto`=1; all three are 0 when `pronto`=0.
- Timing per play: the play pulse arrives in `espera_jogada`. `registraR` is high for 1 cycle, the compare decision follows 1 cycle later, and `contaC` is high for 1 cycle after that. This gives 3 cycles from the pulse to the return to `espera_jogada`.
- Per round: `contaC` pulses exactly 15 times in a full correct round. It never pulses after the last compare.
- `iniciar` held high in `inicial` or a final state: one round starts. Holding it through the round has no further effect until the next final state, where it restarts immediately.
- `jogada_feita` pulses outside `espera_jogada` are ignored.

Test Plan:
- Reset mid-round: assert `reset` while in `proximo` -> `db_estado`=0x0 and all outputs 0 immediately, before the next clock edge. After release, the FSM stays in `inicial` until `iniciar`.
- Full correct round: `iniciar` 1 cycle, then 16 `jogada_feita` pulses with `igual`=1, `fimC`=1 only at the 16th compare. Required: `db_estado` sequence 0x0,0x1,0x2,(0x4,0x5,0x6,0x2)x15,0x4,0x5,0xA; `contaC` pulses 15 times; then `pronto`=`acertou`=1.
- Error on 3rd play: `igual`=0 at the 3rd compare -> next state 0xE, `pronto`=`errou`=1, `contaC` pulsed exactly 2 times; then hold until `iniciar`.
- Timeout: TIMEOUT_EN=1, `fimT`=1 in `espera_jogada` with no play -> 0xD, `pronto`=`timeout`=1. With TIMEOUT_EN=0, the same stimulus keeps the FSM in 0x2 with `contaT`=1.
- Simultaneous events: `jogada_feita`=1 and `fimT`=1 in the same cycle -> 0x4. `igual`=0 with `fimC`=1 -> 0xE, not 0xA.
- Restart from a final state: in 0xA, pulse `iniciar` -> 0x1 with `zeraC`=`zeraR`=`zeraT`=1 for one cycle, then 0x2.

Source files
------------

// File: rtl/unidade_controle_exp6.sv
// Moore control FSM for the exp6 memory game: sequences counter, timer, play register and compare.
// Outputs are registered from the next state, so they change only on the clock or on async reset.
module unidade_controle_exp6 #(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  input  logic       fimT,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    s_inicial       = 4'h0,
    s_preparacao    = 4'h1,
    s_espera_jogada = 4'h2,
    s_registra      = 4'h4,
    s_comparacao    = 4'h5,
    s_proximo       = 4'h6,
    s_fim_acerto    = 4'hA,
    s_fim_timeout   = 4'hD,
    s_fim_erro      = 4'hE
  } estado_t;

  estado_t    state_q, state_d;
  logic [9:0] out_q, out_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_inicial:       state_d = iniciar ? s_preparacao : s_inicial;
      s_preparacao:    state_d = s_espera_jogada;
      s_espera_jogada: begin
        // A play arriving together with timer expiry still counts as a play
        if (jogada_feita)             state_d = s_registra;
        else if (fimT && TIMEOUT_EN)  state_d = s_fim_timeout;
        else                          state_d = s_espera_jogada;
      end
      s_registra:      state_d = s_comparacao;
      s_comparacao: begin
        if (!igual)     state_d = s_fim_erro;
        else if (fimC)  state_d = s_fim_acerto;
        else            state_d = s_proximo;
      end
      s_proximo:       state_d = s_espera_jogada;
      s_fim_acerto, s_fim_erro, s_fim_timeout:
                       state_d = iniciar ? s_preparacao : state_q;
      default:         state_d = s_inicial;
    endcase

    // Bit order: zeraC contaC zeraT contaT zeraR registraR pronto acertou errou timeout
    out_d = '0;
    case (state_d)
      s_preparacao:    out_d = 10'b1010100000;
      s_espera_jogada: out_d = 10'b0001000000;
      s_registra:      out_d = 10'b0010010000;
      s_proximo:       out_d = 10'b0100000000;
      s_fim_acerto:    out_d = 10'b0000001100;
      s_fim_erro:      out_d = 10'b0000001010;
      s_fim_timeout:   out_d = 10'b0000001001;
      default:         out_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= s_inicial;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign {zeraC, contaC, zeraT, contaT, zeraR, registraR,
          pronto, acertou, errou, timeout} = out_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_unidade_controle_exp6.sv
// Bench for unidade_controle_exp6: two instances (timeout enabled / disabled) checked every cycle
// against a state-code reference model driven by directed scenarios and random inputs.
module tb_unidade_controle_exp6;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, igual, fimC, fimT;

  logic [9:0] o0, o1;
  logic [3:0] e0, e1;

  unidade_controle_exp6 u_dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fimC(fimC), .fimT(fimT),
    .zeraC(o0[9]), .contaC(o0[8]), .zeraT(o0[7]), .contaT(o0[6]), .zeraR(o0[5]),
    .registraR(o0[4]), .pronto(o0[3]), .acertou(o0[2]), .errou(o0[1]), .timeout(o0[0]),
    .db_estado(e0)
  );

  unidade_controle_exp6 #(.TIMEOUT_EN(1'b0)) u_dut_nt (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fimC(fimC), .fimT(fimT),
    .zeraC(o1[9]), .contaC(o1[8]), .zeraT(o1[7]), .contaT(o1[6]), .zeraR(o1[5]),
    .registraR(o1[4]), .pronto(o1[3]), .acertou(o1[2]), .errou(o1[1]), .timeout(o1[0]),
    .db_estado(e1)
  );

  always #5 clock = ~clock;

  localparam logic [3:0] INI = 4'h0, PREP = 4'h1, ESP = 4'h2, REG = 4'h4, CMP = 4'h5,
                         PROX = 4'h6, ACE = 4'hA, ERR = 4'hE, TMO = 4'hD;

  int n_cmp = 0;
  int n_err = 0;
  int conta_c = 0;
  logic [3:0] m0, m1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] next_code(input logic [3:0] s, input bit ten);
    case (s)
      INI:  return iniciar ? PREP : INI;
      PREP: return ESP;
      ESP:  return jogada_feita ? REG : ((fimT && ten) ? TMO : ESP);
      REG:  return CMP;
      CMP:  return !igual ? ERR : (fimC ? ACE : PROX);
      PROX: return ESP;
      ACE, ERR, TMO: return iniciar ? PREP : s;
      default: return INI;
    endcase
  endfunction

  // {zeraC,contaC,zeraT,contaT,zeraR,registraR,pronto,acertou,errou,timeout}
  function automatic logic [9:0] exp_outs(input logic [3:0] s);
    case (s)
      PREP: return 10'b1010100000;
      ESP:  return 10'b0001000000;
      REG:  return 10'b0010010000;
      PROX: return 10'b0100000000;
      ACE:  return 10'b0000001100;
      ERR:  return 10'b0000001010;
      TMO:  return 10'b0000001001;
      default: return 10'b0;
    endcase
  endfunction

  task automatic check_all();
    check("u0_estado", {28'd0, e0}, {28'd0, m0});
    check("u0_saidas", {22'd0, o0}, {22'd0, exp_outs(m0)});
    check("u1_estado", {28'd0, e1}, {28'd0, m1});
    check("u1_saidas", {22'd0, o1}, {22'd0, exp_outs(m1)});
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m0 = INI;
      m1 = INI;
    end else begin
      m0 = next_code(m0, 1'b1);
      m1 = next_code(m1, 1'b0);
    end
    #1;
    check_all();
    conta_c += int'(o0[8]);
  endtask

  // Asserts reset in the middle of a cycle; outputs must clear before any edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    m0 = INI;
    m1 = INI;
    #1;
    check_all();
  endtask

  task automatic play(input logic ig, input logic fc);
    jogada_feita = 1'b1;
    igual = ig;
    fimC = fc;
    tick();
    jogada_feita = 1'b0;
    repeat (3) tick();
  endtask

  task automatic start_round();
    conta_c = 0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0;
    igual = 1'b0; fimC = 1'b0; fimT = 1'b0;
    m0 = INI; m1 = INI;
    #1 reset = 1'b1;
    #1 check_all();
    reset = 1'b0;
    repeat (3) tick();

    // Full correct round
    start_round();
    for (int k = 0; k < 16; k++) play(1'b1, k == 15);
    check("contaC_rodada_cheia", conta_c, 15);
    check("acertou_final", {31'd0, o0[2]}, 1);

    // Restart from success state, then error on third play
    start_round();
    play(1'b1, 1'b0);
    play(1'b1, 1'b0);
    play(1'b0, 1'b0);
    check("contaC_erro", conta_c, 2);
    check("errou_final", {31'd0, o0[1]}, 1);
    repeat (2) tick();

    // Timeout with and without TIMEOUT_EN
    start_round();
    fimT = 1'b1;
    tick();
    fimT = 1'b0;
    check("timeout_en1", {28'd0, e0}, {28'd0, TMO});
    check("timeout_en0", {28'd0, e1}, {28'd0, ESP});
    tick();

    // Simultaneous play/timer and mismatch/last position
    do_reset();
    reset = 1'b0;
    start_round();
    jogada_feita = 1'b1; fimT = 1'b1; igual = 1'b0; fimC = 1'b1;
    tick();
    jogada_feita = 1'b0; fimT = 1'b0;
    check("jogada_vs_fimT", {28'd0, e0}, {28'd0, REG});
    tick();
    tick();
    check("erro_vs_fimC", {28'd0, e0}, {28'd0, ERR});

    // Reset while in proximo
    do_reset();
    reset = 1'b0;
    start_round();
    play(1'b1, 1'b0);
    start_round();
    jogada_feita = 1'b1; igual = 1'b1; fimC = 1'b0;
    tick();
    jogada_feita = 1'b0;
    tick();
    tick();
    check("em_proximo", {28'd0, e0}, {28'd0, PROX});
    do_reset();
    reset = 1'b0;
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      iniciar      = ($urandom_range(7) == 0);
      jogada_feita = ($urandom_range(3) == 0);
      igual        = ($urandom_range(7) != 0);
      fimC         = ($urandom_range(7) == 0);
      fimT         = ($urandom_range(15) == 0);
      if ($urandom_range(199) == 0) do_reset();
      else reset = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
